// File: rtl/lm32_ram_fifo_pkg.sv
// lm32_ram_fifo_pkg
//   Shared types and helpers for the RAM-backed FIFO.
//   fifo_acc_t : push/pop requests that were accepted this cycle.
//   accept()   : qualifies a request against its blocking condition.
//   The default for the optional FIFO feature macro (CFG_FIFO_FWFT_EN) is
//   "undefined", which builds the registered-read FIFO.
package lm32_ram_fifo_pkg;

    typedef struct packed {
        logic push;
        logic pop;
    } fifo_acc_t;

    function automatic logic accept(input logic req, input logic blocked);
        return req & ~blocked;
    endfunction

endpackage

// File: rtl/lm32_ram.sv
// lm32_ram
//   Pseudo dual-port RAM, no output register. The read address is captured
//   on read_clk_i when enable_read_i is high and the array is read through
//   that registered address, giving one cycle of read latency. Contents are
//   never reset; only the read address register is.
// Ports:
//   read_clk_i, write_clk_i : read / write clocks (may be tied together)
//   reset_i                 : asynchronous active-high reset of read address
//   enable_read_i           : capture read_address_i this cycle
//   read_address_i          : read address
//   enable_write_i          : write port clock enable
//   write_enable_i          : write strobe (qualified by enable_write_i)
//   write_address_i         : write address
//   write_data_i            : write data
//   read_data_o             : data at the registered read address
module lm32_ram #(
    parameter int data_width    = 32,
    parameter int address_width = 4
) (
    input  logic                     read_clk_i,
    input  logic                     write_clk_i,
    input  logic                     reset_i,
    input  logic                     enable_read_i,
    input  logic [address_width-1:0] read_address_i,
    input  logic                     enable_write_i,
    input  logic                     write_enable_i,
    input  logic [address_width-1:0] write_address_i,
    input  logic [data_width-1:0]    write_data_i,
    output logic [data_width-1:0]    read_data_o
);

    logic [data_width-1:0]    mem_q [0:(1<<address_width)-1];
    logic [address_width-1:0] ra_q;

    always_ff @(posedge write_clk_i) begin
        if (enable_write_i && write_enable_i) begin
            mem_q[write_address_i] <= write_data_i;
        end
    end

    always_ff @(posedge read_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ra_q <= '0;
        end else if (enable_read_i) begin
            ra_q <= read_address_i;
        end
    end

    assign read_data_o = mem_q[ra_q];

endmodule

// File: rtl/lm32_ram_fifo.sv
// lm32_ram_fifo
//   Single-clock FIFO built on one lm32_ram instance, with level count and
//   sticky overflow/underflow flags.
//   Build option: define CFG_FIFO_FWFT_EN for first-word-fall-through mode,
//   where the head entry sits in the RAM read stage and pop_valid_o equals
//   !empty_o. Without it, an accepted pop presents data one cycle later with
//   a one-cycle pop_valid_o pulse.
// Ports:
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset
//   push_i       : write request       push_data_i : write data
//   pop_i        : read request        pop_data_o  : read data (0 when invalid)
//   pop_valid_o  : qualifies pop_data_o
//   full_o       : level == depth      empty_o     : nothing poppable
//   level_o      : stored entries, 0..depth
//   overflow_o   : sticky, push seen while full
//   underflow_o  : sticky, pop seen while empty
module lm32_ram_fifo
    import lm32_ram_fifo_pkg::*;
#(
    parameter int data_width    = 32,
    parameter int address_width = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [data_width-1:0]    push_data_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic [data_width-1:0]    pop_data_o,
    output logic                     pop_valid_o,
    output logic                     empty_o,
    output logic [address_width:0]   level_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int AW    = address_width;
    localparam int LVL_W = address_width + 1;
    localparam int DEPTH = 1 << address_width;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd_en;
    logic [data_width-1:0] ram_rdata;
    fifo_acc_t             acc;

    always_comb begin
        acc.push = accept(push_i, full_q);
`ifdef CFG_FIFO_FWFT_EN
        // Head lives in the RAM read stage. Entries still in RAM are
        // level minus the head; refill the head whenever it is free or
        // being consumed. level_q excludes a push in this cycle, so the
        // address being written is never read in the same cycle.
        acc.pop  = accept(pop_i, ~valid_q);
        rd_en    = ((level_q - LVL_W'(valid_q)) != '0) && (!valid_q || acc.pop);
        valid_d  = rd_en || (valid_q && !acc.pop);
`else
        acc.pop  = accept(pop_i, empty_q);
        rd_en    = acc.pop;
        valid_d  = acc.pop;
`endif
        wr_ptr_d = wr_ptr_q + AW'(acc.push);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        level_d  = level_q + LVL_W'(acc.push) - LVL_W'(acc.pop);
        full_d   = (level_d == LVL_W'(DEPTH));
`ifdef CFG_FIFO_FWFT_EN
        empty_d  = !valid_d;
`else
        empty_d  = (level_d == '0);
`endif
        ovf_d    = ovf_q | (push_i & full_q);
        unf_d    = unf_q | (pop_i & empty_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    lm32_ram #(
        .data_width    (data_width),
        .address_width (address_width)
    ) u_ram (
        .read_clk_i      (clk_i),
        .write_clk_i     (clk_i),
        .reset_i         (rst_i),
        .enable_read_i   (rd_en),
        .read_address_i  (rd_ptr_q),
        .enable_write_i  (1'b1),
        .write_enable_i  (acc.push),
        .write_address_i (wr_ptr_q),
        .write_data_i    (push_data_i),
        .read_data_o     (ram_rdata)
    );

    // Masking keeps the data output at 0 in reset and between pops.
    assign pop_data_o  = valid_q ? ram_rdata : '0;
    assign pop_valid_o = valid_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign level_o     = level_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_lm32_ram_fifo.sv
module tb_lm32_ram_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       push_i = 1'b0;
    logic [7:0] push_data_i = '0;
    logic       full_o;
    logic       pop_i = 1'b0;
    logic [7:0] pop_data_o;
    logic       pop_valid_o;
    logic       empty_o;
    logic [2:0] level_o;
    logic       overflow_o;
    logic       underflow_o;

    int n_checks = 0;
    int n_errors = 0;

    lm32_ram_fifo #(
        .data_width    (8),
        .address_width (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .full_o      (full_o),
        .pop_i       (pop_i),
        .pop_data_o  (pop_data_o),
        .pop_valid_o (pop_valid_o),
        .empty_o     (empty_o),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        push_i = 1'b1;
        push_data_i = d;
        tick();
        push_i = 1'b0;
    endtask

    // One cycle of optional push and optional pop; checks the popped data.
    task automatic xfer(input string tag, input logic do_push, input logic [7:0] pd,
                        input logic do_pop, input logic [7:0] exp);
        push_i = do_push;
        push_data_i = pd;
        pop_i = do_pop;
`ifdef CFG_FIFO_FWFT_EN
        if (do_pop) begin
            chk({tag, "_vld"}, pop_valid_o, 1);
            chk({tag, "_dat"}, pop_data_o, exp);
        end
`endif
        tick();
        push_i = 1'b0;
        pop_i = 1'b0;
`ifndef CFG_FIFO_FWFT_EN
        if (do_pop) begin
            chk({tag, "_vld"}, pop_valid_o, 1);
            chk({tag, "_dat"}, pop_data_o, exp);
        end
`endif
    endtask

    initial begin
        // Reset state
        #1 rst_i = 1'b1;
        tick();
        tick();
        chk("rst_level", level_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_valid", pop_valid_o, 0);
        chk("rst_data", pop_data_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_unf", underflow_o, 0);
        rst_i = 1'b0;
        tick();

        // Single push 0xA5, idle, pop at cycle 2
        push(8'hA5);
        tick();
        chk("a5_level", level_o, 1);
        chk("a5_empty", empty_o, 0);
        xfer("a5_pop", 1'b0, 8'h00, 1'b1, 8'hA5);
        chk("a5_level0", level_o, 0);
        chk("a5_empty1", empty_o, 1);
        tick();
        chk("a5_vld_drop", pop_valid_o, 0);

        // Pop on empty
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        chk("unf_flag", underflow_o, 1);
        chk("unf_valid", pop_valid_o, 0);
        chk("unf_level", level_o, 0);
        tick();
        chk("unf_valid2", pop_valid_o, 0);
        chk("unf_sticky", underflow_o, 1);

        // Fill to depth 4, then overflow
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        chk("fill_full", full_o, 1);
        chk("fill_level", level_o, 4);
        chk("fill_ovf0", overflow_o, 0);
        push(8'h05);
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_level", level_o, 4);

        // Push + pop while full: pop wins, push dropped
        xfer("full_pp", 1'b1, 8'h77, 1'b1, 8'h01);
        chk("full_pp_level", level_o, 3);
        chk("full_pp_full", full_o, 0);
        xfer("pop2", 1'b0, 8'h00, 1'b1, 8'h02);
        xfer("pop3", 1'b0, 8'h00, 1'b1, 8'h03);
        xfer("pop4", 1'b0, 8'h00, 1'b1, 8'h04);
        chk("drain_level", level_o, 0);
        chk("drain_empty", empty_o, 1);
        chk("ovf_sticky", overflow_o, 1);

        // Streaming: 3 entries then 20 cycles of push+pop
        push(8'h10);
        push(8'h11);
        push(8'h12);
        tick();
        for (int i = 0; i < 20; i++) begin
            xfer("stream", 1'b1, 8'(8'h13 + i), 1'b1, 8'(8'h10 + i));
            chk("stream_level", level_o, 3);
        end
        xfer("tail0", 1'b0, 8'h00, 1'b1, 8'h24);
        xfer("tail1", 1'b0, 8'h00, 1'b1, 8'h25);
        xfer("tail2", 1'b0, 8'h00, 1'b1, 8'h26);
        chk("stream_empty", empty_o, 1);

        // Asynchronous reset with 2 entries and a pop in flight
        push(8'hB1);
        push(8'hB2);
        tick();
        pop_i = 1'b1;
        @(posedge clk_i);
        #2;
        pop_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", pop_valid_o, 0);
        chk("arst_data", pop_data_o, 0);
        chk("arst_level", level_o, 0);
        chk("arst_empty", empty_o, 1);
        chk("arst_ovf", overflow_o, 0);
        chk("arst_unf", underflow_o, 0);
        tick();
        rst_i = 1'b0;
        chk("arst_valid2", pop_valid_o, 0);
        tick();
        chk("arst_valid3", pop_valid_o, 0);
        push(8'hC3);
        tick();
        chk("post_level", level_o, 1);
        xfer("post_pop", 1'b0, 8'h00, 1'b1, 8'hC3);
        chk("post_empty", empty_o, 1);
        chk("post_level0", level_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lm32_ram_fifo.md
LM32_RAM_FIFO -- requirements
Module: lm32_ram_fifo

Interface
REQ-001 Parameter data_width, default 32, SHALL set the entry width in bits.
REQ-002 Parameter address_width, default 4, SHALL set depth = 2^address_width entries.
REQ-003 clk_i  input  1  SHALL be the single clock for all logic, with read_clk and write_clk of the RAM tied to it.
REQ-004 rst_i  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 push_i  input  1  SHALL be the write request.
REQ-006 push_data_i  input  data_width  SHALL be the write data.
REQ-007 full_o  output  1  SHALL indicate that level equals depth.
REQ-008 pop_i  input  1  SHALL be the read request.
REQ-009 pop_data_o  output  data_width  SHALL be the read data.
REQ-010 pop_valid_o  output  1  SHALL qualify pop_data_o.
REQ-011 empty_o  output  1  SHALL indicate that no entry is poppable.
REQ-012 level_o  output  address_width+1  SHALL be the stored entry count, 0..depth.
REQ-013 overflow_o and underflow_o  output  1 each  SHALL be sticky error flags.

Function
REQ-014 Push SHALL be accepted iff push_i && !full_o; the accepted push writes RAM[wr_ptr] and increments wr_ptr modulo depth.
REQ-015 Pop SHALL be accepted iff pop_i && !empty_o; the accepted pop increments rd_ptr modulo depth.
REQ-016 Pointers SHALL be address_width bits and wrap naturally from depth-1 to 0.
REQ-017 level_o SHALL be +1 on push only, -1 on pop only, and unchanged when both are accepted in the same cycle.
REQ-018 full_o and the push side of empty_o SHALL be registered, and SHALL update the cycle after the accepted event.
REQ-019 A simultaneous push and pop while full SHALL accept the pop and reject the push.
REQ-020 A simultaneous push and pop while empty SHALL accept the push and reject the pop.
REQ-021 A push with full_o high SHALL set overflow_o; a pop with empty_o high SHALL set underflow_o; both flags SHALL stay set until reset.
REQ-022 Rejected requests SHALL leave pointers, level, and RAM unchanged.
REQ-023 The RAM SHALL never be read at an address written in the same cycle.

Reset
REQ-024 While rst_i is high, wr_ptr, rd_ptr, level_o, full_o, pop_valid_o, overflow_o, and underflow_o SHALL be 0, and empty_o SHALL be 1.
REQ-025 The pop_data_o output register, when present, SHALL reset to 0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL discard all entries and any pending pop_valid_o.

Configuration
REQ-028 Macro CFG_FIFO_FWFT_EN SHALL select first-word-fall-through read mode.
REQ-029 Without CFG_FIFO_FWFT_EN: an accepted pop at cycle N SHALL present data with pop_valid_o=1 at N+1 (one-cycle RAM read latency); empty_o = (level==0); pop_valid_o is a one-cycle pulse.
REQ-030 With CFG_FIFO_FWFT_EN: head data SHALL be prefetched into an output register.
REQ-031 In FWFT mode, pop_valid_o SHALL equal !empty_o and pop_data_o SHALL show the head entry while pop_valid_o=1.
REQ-032 In FWFT mode, a pop SHALL consume the head, and the next entry SHALL appear the following cycle.
REQ-033 In FWFT mode, the first push into an empty FIFO SHALL clear empty_o two cycles after acceptance.
REQ-034 In FWFT mode, level_o SHALL include the prefetched entry.

Structure
REQ-035 Storage SHALL be one lm32_ram instance (pseudo dual-port, noreg), with enable_read, enable_write, and write_enable driven by the FIFO control.
REQ-036 The CFG_FIFO_FWFT_EN default SHALL live in lm32_include.v alongside the other CFG_ macros; no new package is required.
REQ-037 Pointer/level logic and FWFT prefetch SHALL reside in this module, with no other sub-modules.

Verification
REQ-038 Reset, then push 0xA5 at cycle 0, then pop at cycle 2 -> non-FWFT: pop_data_o=0xA5 with pop_valid_o=1 at cycle 3 and level_o=0 at cycle 3; FWFT: pop_valid_o=1 with data 0xA5 from cycle 2.
REQ-039 address_width=2: push 1,2,3,4 -> full_o=1 and level_o=4; a fifth push sets overflow_o and 1..4 pop back in order.
REQ-040 Fill 3 entries, then 20 cycles of simultaneous push/pop with an incrementing pattern -> level_o constant 3, data in order, and both pointers wrap at least 4 times.
REQ-041 Pop on empty after reset -> underflow_o=1, pop_valid_o stays 0, level_o=0; push while full with simultaneous pop -> pop accepted, push dropped, level_o=depth-1.
REQ-042 Assert rst_i asynchronously with 2 entries stored and a pop in flight -> outputs take reset values immediately, no pop_valid_o follows, and subsequent push/pop returns only new data.
